branch_unit: RTL
================

# branch_unit

Control-transfer resolution block for the pipelined LC-3 datapath; it consumes the N/Z/P condition codes produced by the condition-code register. It sits in the execute stage. For BR, JMP/RET, JSR and JSRR it:
- evaluates the branch condition, forwarding a same-cycle condition-code write;
- computes the target;
- issues a registered fetch redirect, R7 link write and wrong-path squash window;
- keeps branch/taken performance counters.

## Interface
Parameters:
- FLUSH_DEPTH, 2, number of non-stalled cycles `flush` stays high per taken transfer; legal range 1..7.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; one clock, synchronous reset.
- stall  in  1  pipeline stall; no instruction accepted, squash counter frozen.
- br_valid  in  1  execute-stage instruction is a control transfer.
- br_op  in  2  00 BR, 01 JMP/RET, 10 JSR, 11 JSRR.
- br_cond  in  3  nzp mask, IR[11:9] (bit2=n, bit1=z, bit0=p).
- pc_plus1  in  16  incremented PC of the transfer.
- offset  in  16  sign-extended PC offset.
- base_reg  in  16  BaseR value.
- cc_N, cc_Z, cc_P  in  1 each  architectural condition codes.
- cc_fwd_valid  in  1  a condition-code write is occurring this cycle.
- cc_fwd_data  in  16  value being written.
- redirect  out  1  fetch loads `redirect_pc`.
- redirect_pc  out  16  transfer target.
- link_we  out  1  write R7.
- link_data  out  16  return address.
- flush  out  1  squash younger pipeline slots.
- br_count  out  16  accepted transfers.
- taken_count  out  16  taken transfers.

## Operation
- **Accept:** a transfer is accepted when state is IDLE, `br_valid`=1 and `stall`=0. Otherwise the input is ignored.
- **Effective CC source:**
  - If `cc_fwd_valid`=1, effective CC comes from `cc_fwd_data`: N = bit 15; Z = (data == 0); P = neither. This is a signed decision.
  - Otherwise effective CC is `{cc_N, cc_Z, cc_P}`.
- **Taken decision:**
  - BR is taken iff `(br_cond & effective_nzp) != 0`. `br_cond`=000 is never taken; 111 is always taken.
  - JMP, JSR and JSRR are always taken.
- **Target:**
  - BR and JSR: `pc_plus1 + offset`, mod 2^16, wraps silently.
  - JMP and JSRR: `base_reg`.
- **Link:** JSR and JSRR set `link_we` and drive `link_data = pc_plus1`.
- **Counters:** `br_count` +1 per accepted transfer; `taken_count` +1 per taken transfer. Both are 16-bit and wrap from 0xFFFF to 0.
- **FSM states:**
  - IDLE: `flush`=0.
  - SQUASH: `flush`=1. `br_valid` is ignored (wrong-path instruction).
- **Transitions:**
  - IDLE → SQUASH on an accepted taken transfer. `cnt` loads FLUSH_DEPTH.
  - An accepted not-taken transfer stays in IDLE with no outputs raised.
  - In SQUASH, each cycle with `stall`=0 decrements `cnt`. When `cnt`==1 and `stall`=0, the next state is IDLE.
- **Reset:** all outputs and counters go to 0 and state to IDLE on the next edge. This applies mid-SQUASH too; a pending redirect is dropped.

## Timing
- Resolution latency is 1 cycle. Acceptance at edge k sets `redirect`, `redirect_pc`, `link_we` and `link_data` after edge k, and enters SQUASH at the same edge.
- `redirect`/`link_we` rules:
  - They stay high while `stall`=1.
  - They clear after the first cycle in which `stall`=0. The fetch stage therefore sees exactly one non-stalled redirect cycle.
  - `redirect_pc` and `link_data` hold until the next taken transfer.
- `flush` is high for exactly FLUSH_DEPTH non-stalled cycles, plus any stalled cycles interleaved. The first of those cycles is the redirect cycle.
- A new transfer can be accepted in the first cycle back in IDLE (back-to-back after the squash window).
- Counters update at the accepting edge and are visible the next cycle.
- `cc_fwd` is combinational into the decision. The registered CC inputs are not consulted when `cc_fwd_valid`=1.

## Structure
- Package `lc3_br_pkg`:
  - `br_op_t` enum (BR, JMP, JSR, JSRR);
  - `br_state_t` (IDLE, SQUASH);
  - function `cc_from_data(logic [15:0]) -> logic [2:0]`.
- Sub-module `br_cond_eval` (combinational):
  - inputs: forward mux, `cc_from_data`, mask test;
  - output: `taken`.
- Target adder, FSM, output registers and counters live in `branch_unit`.

## Test plan
1. Reset, then BRz with `cc_Z`=1, `pc_plus1`=0x3001, `offset`=0xFFFE (FLUSH_DEPTH=2) → next cycle `redirect`=1, `redirect_pc`=0x2FFF; `flush`=1 for 2 cycles; `taken_count`=1, `br_count`=1.
2. `cc_P`=1, `cc_fwd_valid`=1, `cc_fwd_data`=0x8000:
   - BRn → taken.
   - Repeat with BRp → no redirect; `br_count` increments, `taken_count` unchanged.
   - Same stimulus, BR with `br_cond`=000 → never taken.
3. JSRR `base_reg`=0x4000, `pc_plus1`=0x3010 → `redirect_pc`=0x4000, `link_we`=1, `link_data`=0x3010. Then JSR `pc_plus1`=0xFFFF, `offset`=0x0002 → `redirect_pc`=0x0001.
4. Taken JMP, then `stall`=1 for 3 cycles after acceptance:
   - `redirect` held through the stall, then exactly 1 non-stalled cycle;
   - `flush` ends after 2 non-stalled cycles;
   - `br_valid` pulses during SQUASH leave counters unchanged.
5. `br_valid`=1 with `stall`=1 → no redirect, counters unchanged. Same instruction with `stall`=0 → accepted once.
6. Assert `Reset` in the second SQUASH cycle → next cycle `flush`=0, `redirect`=0, `link_we`=0, both counters 0. A transfer is accepted immediately after.

Source files
------------

// File: rtl/lc3_br_pkg.sv
// Shared types and condition-code helper for the LC-3 branch unit.
package lc3_br_pkg;

    typedef enum logic [1:0] {
        OP_BR   = 2'b00,
        OP_JMP  = 2'b01,
        OP_JSR  = 2'b10,
        OP_JSRR = 2'b11
    } br_op_t;

    typedef enum logic {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } br_state_t;

    function automatic logic [2:0] cc_from_data(input logic [15:0] d);
        logic n, z;
        n = d[15];
        z = (d == 16'h0000);
        return {n, z, ~n & ~z};
    endfunction

endpackage

// File: rtl/branch_unit_cond_eval.sv
// Taken decision: forwarded or architectural CC against the nzp mask.
module br_cond_eval
    import lc3_br_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [2:0]  cond,
    input  logic        cc_N,
    input  logic        cc_Z,
    input  logic        cc_P,
    input  logic        fwd_valid,
    input  logic [15:0] fwd_data,
    output logic        taken
);

    logic [2:0] nzp;

    always_comb begin
        nzp = fwd_valid ? cc_from_data(fwd_data) : {cc_N, cc_Z, cc_P};
        if (br_op_t'(op) == OP_BR)
            taken = |(cond & nzp);
        else
            taken = 1'b1;
    end

endmodule

// File: rtl/branch_unit.sv
// Execute-stage control-transfer resolution: target, redirect, link,
// squash window and performance counters.
module branch_unit
    import lc3_br_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [1:0]  br_op,
    input  logic [2:0]  br_cond,
    input  logic [15:0] pc_plus1,
    input  logic [15:0] offset,
    input  logic [15:0] base_reg,
    input  logic        cc_N,
    input  logic        cc_Z,
    input  logic        cc_P,
    input  logic        cc_fwd_valid,
    input  logic [15:0] cc_fwd_data,
    output logic        redirect,
    output logic [15:0] redirect_pc,
    output logic        link_we,
    output logic [15:0] link_data,
    output logic        flush,
    output logic [15:0] br_count,
    output logic [15:0] taken_count
);

    br_state_t  state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic       taken;
    logic       accept;
    logic       take;
    logic       is_link;
    logic [15:0] target;
    br_op_t     op;

    assign op = br_op_t'(br_op);

    br_cond_eval u_cond (
        .op        (br_op),
        .cond      (br_cond),
        .cc_N      (cc_N),
        .cc_Z      (cc_Z),
        .cc_P      (cc_P),
        .fwd_valid (cc_fwd_valid),
        .fwd_data  (cc_fwd_data),
        .taken     (taken)
    );

    assign accept  = (state == IDLE) && br_valid && !stall;
    assign take    = accept && taken;
    assign is_link = (op == OP_JSR) || (op == OP_JSRR);
    assign target  = ((op == OP_JMP) || (op == OP_JSRR))
                   ? base_reg : pc_plus1 + offset;
    assign flush   = (state == SQUASH);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (take) begin
                    state_nx = SQUASH;
                    cnt_nx   = 3'(FLUSH_DEPTH);
                end
            end
            SQUASH: begin
                if (!stall) begin
                    cnt_nx = cnt - 3'd1;
                    if (cnt == 3'd1)
                        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Redirect and link pulses persist across stalls; first free cycle ends them.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            redirect    <= 1'b0;
            redirect_pc <= 16'h0000;
            link_we     <= 1'b0;
            link_data   <= 16'h0000;
            br_count    <= 16'h0000;
            taken_count <= 16'h0000;
        end else begin
            if (take) begin
                redirect    <= 1'b1;
                redirect_pc <= target;
                link_we     <= is_link;
                link_data   <= pc_plus1;
            end else if (!stall) begin
                redirect <= 1'b0;
                link_we  <= 1'b0;
            end
            if (accept)
                br_count <= br_count + 16'd1;
            if (take)
                taken_count <= taken_count + 16'd1;
        end
    end

endmodule
